fc_lane_array: RTL and testbench

Parametrised fully-connected compute core: KPF output lanes each take a CPF-wide dot product of streamed input beats with packed low-precision weights. Each lane accumulates across beats until eop, adds a shifted bias, and applies optional ReLU, rounding and saturation. Results go into a small output FIFO with valid/ready and credit-based input backpressure. It sits between the layer controller plus RM/WM/BM RAMs and the next layer's blob input.

---
 rtl/fc_pkg.sv | 60 ++++++
 rtl/fc_out_fifo.sv | 55 +++++
 rtl/fc_lane_array.sv | 212 +++++++++++++++++++++
 tb/tb_fc_lane_array.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared helpers for the FC lane array: slice index arithmetic and the
// round/saturate steps used when finalising a lane result.
package fc_pkg;

    localparam int WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic  hit;
        wide_t val;
    } sat_res_t;

    // Never returns less than 1 so depth-1 FIFOs still get a 1-bit pointer.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ch_lsb(input int c, input int dw);
        return c * dw;
    endfunction

    function automatic int wt_lsb(input int k, input int c, input int cpf, input int wq);
        return (k * cpf + c) * wq;
    endfunction

    function automatic int lane_lsb(input int k, input int dw);
        return k * dw;
    endfunction

    // Round half up, then arithmetic shift down to the output scale.
    function automatic wide_t round_shr(input wide_t v, input int shr);
        wide_t half;
        if (shr <= 0) return v;
        half = wide_t'(1) <<< (shr - 1);
        return (v + half) >>> shr;
    endfunction

    function automatic sat_res_t sat_clip(input wide_t v, input int w);
        sat_res_t res;
        wide_t    hi;
        wide_t    lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        res.hit = 1'b0;
        res.val = v;
        if (v > hi) begin
            res.hit = 1'b1;
            res.val = hi;
        end else if (v < lo) begin
            res.hit = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_out_fifo.sv
// Show-ahead result FIFO; head word is presented whenever the FIFO is non-empty
// and reads as zero when empty.
module fc_out_fifo
    import fc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DW-1:0]                 din,
    input  logic                          pop,
    output logic [DW-1:0]                 dout,
    output logic                          nonempty,
    output logic [clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign nonempty = (count != '0);
    assign dout     = nonempty ? mem[rd_ptr] : '0;

    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);

endmodule

// File: rtl/fc_lane_array.sv
// FC compute core: KPF lanes of CPF-wide signed dot products, accumulated per
// vector, biased, rounded/saturated and queued behind a credit-protected FIFO.
module fc_lane_array
    import fc_pkg::*;
#(
    parameter int CPF       = 4,
    parameter int KPF       = 4,
    parameter int DIN_DW    = 16,
    parameter int WQ        = 4,
    parameter int BQ        = 4,
    parameter int ACC_W     = 40,
    parameter int DOUT_DW   = 16,
    parameter int BIAS_SHL  = 4,
    parameter int OUT_SHR   = 4,
    parameter int RELU      = 0,
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_din_en,
    input  logic                    op_din_eop,
    input  logic [CPF*DIN_DW-1:0]   op_din,
    input  logic [KPF*CPF*WQ-1:0]   op_weight,
    input  logic [KPF*BQ-1:0]       op_bias,
    output logic                    op_din_rdy,
    output logic                    dout_en,
    input  logic                    dout_rdy,
    output logic [KPF*DOUT_DW-1:0]  dout,
    output logic [KPF-1:0]          sat_flag,
    input  logic                    sat_clr,
    output logic                    proto_err
);
    localparam int PROD_W = DIN_DW + WQ;
    localparam int CNT_W  = clog2(OUT_DEPTH + 1);

    logic             accept;
    logic             accept_eop;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W:0]   credit_used;

    // Every eop in the pipe already owns a FIFO slot, so a push can never overflow.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign op_din_rdy  = credit_used < (CNT_W + 1)'(OUT_DEPTH);
    assign accept      = op_din_en & op_din_rdy;
    assign accept_eop  = accept & op_din_eop;

    logic signed [PROD_W-1:0] din_x  [CPF];
    logic signed [PROD_W-1:0] wt_x   [KPF][CPF];
    logic signed [PROD_W-1:0] prod   [KPF][CPF];

    always_comb begin
        for (int c = 0; c < CPF; c++) begin
            din_x[c] = PROD_W'($signed(op_din[ch_lsb(c, DIN_DW) +: DIN_DW]));
        end
        for (int k = 0; k < KPF; k++) begin
            for (int c = 0; c < CPF; c++) begin
                wt_x[k][c] = PROD_W'($signed(op_weight[wt_lsb(k, c, CPF, WQ) +: WQ]));
                prod[k][c] = din_x[c] * wt_x[k][c];
            end
        end
    end

    logic                     s1_vld;
    logic                     s1_eop;
    logic [KPF*BQ-1:0]        s1_bias;
    logic signed [PROD_W-1:0] s1_prod [KPF][CPF];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_bias <= '0;
            for (int k = 0; k < KPF; k++)
                for (int c = 0; c < CPF; c++) s1_prod[k][c] <= '0;
        end else begin
            s1_vld <= accept;
            s1_eop <= accept_eop;
            if (accept) begin
                s1_bias <= op_bias;
                for (int k = 0; k < KPF; k++)
                    for (int c = 0; c < CPF; c++) s1_prod[k][c] <= prod[k][c];
            end
        end
    end

    logic signed [ACC_W-1:0] lane_sum [KPF];

    always_comb begin
        for (int k = 0; k < KPF; k++) begin
            lane_sum[k] = '0;
            for (int c = 0; c < CPF; c++) lane_sum[k] = lane_sum[k] + ACC_W'(s1_prod[k][c]);
        end
    end

    logic                    s2_vld;
    logic                    s2_eop;
    logic [KPF*BQ-1:0]       s2_bias;
    logic signed [ACC_W-1:0] s2_sum [KPF];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld  <= 1'b0;
            s2_eop  <= 1'b0;
            s2_bias <= '0;
            for (int k = 0; k < KPF; k++) s2_sum[k] <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_eop <= s1_eop;
            if (s1_vld) begin
                s2_bias <= s1_bias;
                for (int k = 0; k < KPF; k++) s2_sum[k] <= lane_sum[k];
            end
        end
    end

    logic                    first;
    logic                    s3_vld;
    logic signed [ACC_W-1:0] acc      [KPF];
    logic signed [ACC_W-1:0] acc_next [KPF];
    logic signed [ACC_W-1:0] bias_sh  [KPF];
    logic signed [ACC_W-1:0] s3_total [KPF];

    always_comb begin
        for (int k = 0; k < KPF; k++) begin
            acc_next[k] = first ? s2_sum[k] : acc[k] + s2_sum[k];
            bias_sh[k]  = ACC_W'($signed(s2_bias[lane_lsb(k, BQ) +: BQ])) <<< BIAS_SHL;
        end
    end

    // first re-arms on every eop so a new vector never sees the old accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first  <= 1'b1;
            s3_vld <= 1'b0;
            for (int k = 0; k < KPF; k++) begin
                acc[k]      <= '0;
                s3_total[k] <= '0;
            end
        end else begin
            s3_vld <= s2_vld & s2_eop;
            if (s2_vld) begin
                first <= s2_eop;
                for (int k = 0; k < KPF; k++) acc[k] <= acc_next[k];
            end
            if (s2_vld && s2_eop) begin
                for (int k = 0; k < KPF; k++) s3_total[k] <= acc_next[k] + bias_sh[k];
            end
        end
    end

    wide_t                  fin_val [KPF];
    sat_res_t               fin_res [KPF];
    logic [KPF-1:0]         lane_hit;
    logic [KPF*DOUT_DW-1:0] fifo_din;

    always_comb begin
        lane_hit = '0;
        fifo_din = '0;
        for (int k = 0; k < KPF; k++) begin
            fin_val[k] = wide_t'(s3_total[k]);
            if (RELU != 0 && fin_val[k] < 0) fin_val[k] = '0;
            fin_val[k] = round_shr(fin_val[k], OUT_SHR);
            fin_res[k] = sat_clip(fin_val[k], DOUT_DW);
            lane_hit[k] = fin_res[k].hit;
            fifo_din[lane_lsb(k, DOUT_DW) +: DOUT_DW] = fin_res[k].val[DOUT_DW-1:0];
        end
    end

    assign push = s3_vld;
    assign pop  = dout_en & dout_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({accept_eop, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // A fresh clamp wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag  <= '0;
            proto_err <= 1'b0;
        end else begin
            sat_flag <= (sat_clr ? '0 : sat_flag) | (push ? lane_hit : '0);
            if (op_din_en && !op_din_rdy) proto_err <= 1'b1;
        end
    end

    fc_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .DW    (KPF * DOUT_DW)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (fifo_din),
        .pop      (pop),
        .dout     (dout),
        .nonempty (dout_en),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_fc_lane_array.sv
// Randomised bench for fc_lane_array: a RELU=0 and a RELU=1 instance share stimulus
// and are checked every cycle against an arithmetic reference of the FC rules.
module tb_fc_lane_array;

    localparam int DEPTH = 2;

    localparam logic [63:0] T1_DIN  = {4{16'h0010}};
    localparam logic [63:0] T1_WT   = {16'h8888, 16'h7777, 16'hFFFF, 16'h1111};
    localparam logic [63:0] G1      = 64'hFFE0_001C_FFFC_0004;
    localparam logic [63:0] G1_RELU = 64'h0000_001C_0000_0004;
    localparam logic [63:0] G2      = 64'hFFC0_0038_FFF8_0008;
    localparam logic [63:0] G3      = 64'hFFA0_0054_FFF4_000C;
    localparam logic [63:0] T2_DIN  = {4{16'h0100}};
    localparam logic [63:0] T2_WT   = 64'h0000_0000_0000_1111;
    localparam logic [63:0] T3_DIN  = {4{16'h7FFF}};
    localparam logic [63:0] T3_WT   = 64'h0000_0000_8888_7777;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        eop = 1'b0;
    logic        dout_rdy = 1'b0;
    logic        sat_clr = 1'b0;
    logic [63:0] din = '0;
    logic [63:0] wt = '0;
    logic [15:0] bias = '0;

    logic        rdy0, rdy1, den0, den1, perr0, perr1;
    logic [63:0] dout0, dout1;
    logic [3:0]  sat0, sat1;

    always #5 clk = ~clk;

    fc_lane_array #(.RELU(0)) u_dut (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(wt), .op_bias(bias), .op_din_rdy(rdy0), .dout_en(den0),
        .dout_rdy(dout_rdy), .dout(dout0), .sat_flag(sat0), .sat_clr(sat_clr),
        .proto_err(perr0)
    );

    fc_lane_array #(.RELU(1)) u_dut_relu (
        .clk(clk), .rst(rst), .op_din_en(en), .op_din_eop(eop), .op_din(din),
        .op_weight(wt), .op_bias(bias), .op_din_rdy(rdy1), .dout_en(den1),
        .dout_rdy(dout_rdy), .dout(dout1), .sat_flag(sat1), .sat_clr(sat_clr),
        .proto_err(perr1)
    );

    typedef struct {
        logic [63:0] d0;
        logic [63:0] d1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        int          due;
    } exp_t;

    exp_t        q[$];
    longint      run[4];
    int          outstanding;
    logic [3:0]  mflag0, mflag1;
    logic        mperr;
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    bit          collect = 0;
    logic [63:0] got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        longint r;
        r = longint'(v & ((64'd1 << w) - 64'd1));
        if (v[w-1]) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic void finalize(input longint v, input bit relu,
                                     output logic [15:0] o, output logic hit);
        longint r;
        if (relu && v < 0) v = 0;
        r   = (v + 8) >>> 4;
        hit = 1'b0;
        if (r > 32767) begin
            r = 32767; hit = 1'b1;
        end else if (r < -32768) begin
            r = -32768; hit = 1'b1;
        end
        o = r[15:0];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 4; k++) run[k] = 0;
        outstanding = 0;
        mflag0 = '0;
        mflag1 = '0;
        mperr  = 1'b0;
    endtask

    task automatic model_beat();
        exp_t        e;
        longint      total;
        logic [15:0] o;
        logic        h;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                run[k] += sx(din[c*16 +: 16], 16) * sx(wt[(k*4+c)*4 +: 4], 4);
        if (eop) begin
            e.d0 = '0; e.d1 = '0; e.s0 = '0; e.s1 = '0;
            e.due = cyc + 3;
            for (int k = 0; k < 4; k++) begin
                total = run[k] + sx(bias[k*4 +: 4], 4) * 16;
                finalize(total, 1'b0, o, h);
                e.d0[k*16 +: 16] = o;
                e.s0[k] = h;
                finalize(total, 1'b1, o, h);
                e.d1[k*16 +: 16] = o;
                e.s1[k] = h;
                run[k] = 0;
            end
            q.push_back(e);
            outstanding++;
        end
    endtask

    task automatic check_outputs();
        logic        exp_en;
        logic [63:0] exp_d0, exp_d1;
        exp_en = (q.size() > 0) && (q[0].due <= cyc);
        exp_d0 = exp_en ? q[0].d0 : 64'd0;
        exp_d1 = exp_en ? q[0].d1 : 64'd0;
        chk("rdy", rdy0, outstanding < DEPTH);
        chk("rdy_relu", rdy1, outstanding < DEPTH);
        chk("dout_en", den0, exp_en);
        chk("dout_en_relu", den1, exp_en);
        chk("dout", dout0, exp_d0);
        chk("dout_relu", dout1, exp_d1);
        chk("sat_flag", sat0, mflag0);
        chk("sat_flag_relu", sat1, mflag1);
        chk("proto_err", perr0, mperr);
        chk("proto_err_relu", perr1, mperr);
    endtask

    task automatic tick();
        logic mrdy, acc, pop;
        mrdy = (outstanding < DEPTH);
        acc  = en && mrdy;
        pop  = dout_rdy && (q.size() > 0) && (q[0].due <= cyc);
        if (collect && den0 && dout_rdy) got.push_back(dout0);
        @(posedge clk);
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            if (en && !mrdy) mperr = 1'b1;
            if (pop) begin
                q.delete(0);
                outstanding--;
            end
            if (acc) model_beat();
            if (sat_clr) begin
                mflag0 = '0;
                mflag1 = '0;
            end
            foreach (q[i]) if (q[i].due == cyc) begin
                mflag0 |= q[i].s0;
                mflag1 |= q[i].s1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] w,
                        input logic [15:0] b, input logic e);
        int n;
        n  = 0;
        en = 1'b0;
        while (outstanding >= DEPTH && n < 50) begin
            tick();
            n++;
        end
        chk("send_wait", 64'(n < 50), 64'd1);
        din = d; wt = w; bias = b; eop = e; en = 1'b1;
        tick();
        en = 1'b0; eop = 1'b0;
    endtask

    task automatic wait_den(input string tag);
        int n;
        n = 0;
        while (!den0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, den0, 1'b1);
    endtask

    task automatic pop_one();
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
    endtask

    task automatic rand_phase(input int ncyc, input bit obey);
        for (int i = 0; i < ncyc; i++) begin
            for (int c = 0; c < 4; c++)
                din[c*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                : 16'(int'($urandom_range(0, 1023)) - 512);
            wt       = {$urandom, $urandom};
            bias     = 16'($urandom);
            eop      = ($urandom_range(0, 2) == 0);
            en       = obey ? (($urandom_range(0, 3) != 0) && outstanding < DEPTH)
                            : ($urandom_range(0, 2) != 0);
            dout_rdy = ($urandom_range(0, 3) != 0);
            sat_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end
        en = 1'b0; eop = 1'b0; sat_clr = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 1'b1);
        dout_rdy = 1'b1;
        for (int n = 0; n < 40 && q.size() > 0; n++) tick();
        chk("drain_empty", den0, 1'b0);
        dout_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_dout_en", den0, 1'b0);
        chk("rst_dout", dout0, 64'd0);
        chk("rst_rdy", rdy0, 1'b1);
        chk("rst_sat", sat0, 4'd0);

        // single beat, 4-cycle latency
        send(T1_DIN, T1_WT, 16'h0000, 1'b1);
        tick(); tick();
        chk("t1_lat_early", den0, 1'b0);
        tick();
        chk("t1_lat", den0, 1'b1);
        chk("t1_dout", dout0, G1);
        chk("t1_dout_relu", dout1, G1_RELU);
        pop_one();

        // 3-beat accumulate with bias, then a fresh vector
        send(T2_DIN, T2_WT, 16'hFFFF, 1'b0);
        send(T2_DIN, T2_WT, 16'hFFFF, 1'b0);
        send(T2_DIN, T2_WT, 16'h0002, 1'b1);
        wait_den("t2_wait");
        chk("t2_dout", dout0, 64'h0000_0000_0000_00C2);
        chk("t2_dout_relu", dout1, 64'h0000_0000_0000_00C2);
        pop_one();
        send(T2_DIN, T2_WT, 16'h0000, 1'b1);
        wait_den("t2b_wait");
        chk("t2_rearm", dout0, 64'h0000_0000_0000_0040);
        pop_one();

        // saturation and sticky flag clear
        send(T3_DIN, T3_WT, 16'h0000, 1'b0);
        send(T3_DIN, T3_WT, 16'h0000, 1'b1);
        wait_den("t3_wait");
        chk("t3_dout", dout0, 64'h0000_0000_8000_7FFF);
        chk("t3_dout_relu", dout1, 64'h0000_0000_0000_7FFF);
        chk("t3_sat", sat0, 4'b0011);
        chk("t3_sat_relu", sat1, 4'b0001);
        pop_one();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("t3_sat_clr", sat0, 4'd0);

        rand_phase(1500, 1'b1);

        // backpressure with a held third vector, plus a dropped beat
        dout_rdy = 1'b0;
        send({4{16'h0010}}, T1_WT, 16'h0000, 1'b1);
        chk("t4_rdy_after1", rdy0, 1'b1);
        send({4{16'h0020}}, T1_WT, 16'h0000, 1'b1);
        chk("t4_rdy_low", rdy0, 1'b0);
        repeat (6) tick();
        chk("t4_hold_rdy", rdy0, 1'b0);
        chk("t4_no_perr", perr0, 1'b0);
        din = {4{16'h1234}}; wt = T1_WT; bias = 16'h0000; eop = 1'b1; en = 1'b1;
        tick();
        en = 1'b0; eop = 1'b0;
        chk("t5_perr", perr0, 1'b1);
        chk("t5_perr_relu", perr1, 1'b1);
        got.delete();
        collect  = 1'b1;
        dout_rdy = 1'b1;
        send({4{16'h0030}}, T1_WT, 16'h0000, 1'b1);
        repeat (12) tick();
        collect = 1'b0;
        chk("t4_count", 64'(got.size()), 64'd3);
        chk("t4_order0", got[0], G1);
        chk("t4_order1", got[1], G2);
        chk("t4_order2", got[2], G3);
        dout_rdy = 1'b0;

        rand_phase(800, 1'b0);

        // reset part-way through a vector while a result is queued
        send(T1_DIN, T1_WT, 16'h0000, 1'b1);
        wait_den("t6_fill");
        send(T2_DIN, T2_WT, 16'h0000, 1'b0);
        send(T2_DIN, T2_WT, 16'h0000, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_den_rst", den0, 1'b0);
        chk("t6_den_rst_relu", den1, 1'b0);
        chk("t6_dout_rst", dout0, 64'd0);
        chk("t6_perr_rst", perr0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        send(T1_DIN, T1_WT, 16'h0000, 1'b1);
        wait_den("t6_wait");
        chk("t6_clean", dout0, G1);
        chk("t6_clean_relu", dout1, G1_RELU);
        pop_one();

        rand_phase(300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
